// File: rtl/memory2_if.sv
// memory2 pass bundles and the stage interface.
// fwd_* signals exist only when MEM2_FWD_EN is defined.
package memory2_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic [31:0] pc_plus4;
    logic        is_wr_csr;
    logic [11:0] csr_addr;
    logic        is_ld;
    logic        is_st;
    logic [2:0]  mem_type;
    logic [31:0] va;
    logic [31:0] pa;
    logic [31:0] ex_out;
    logic [31:0] st_data;
  } memory1_memory2_pass_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        is_wr_rd;
    logic        is_wr_rd_pc_plus4;
    logic [31:0] pc_plus4;
    logic        is_wr_csr;
    logic [11:0] csr_addr;
    logic        is_ld;
    logic        is_st;
    logic [2:0]  mem_type;
    logic [31:0] va;
    logic [31:0] pa;
    logic [31:0] ex_mem_out;
    logic [31:0] st_data;
  } memory2_writeback_pass_t;

endpackage

interface memory2_if;
  import memory2_pkg::*;

  logic                    flush;
  logic                    next_rdy_in;
  logic                    rdy_in;
  memory1_memory2_pass_t   pass_in;
  memory2_writeback_pass_t pass_out;
  logic                    dc_resp_valid;
  logic [31:0]             dc_resp_data;
`ifdef MEM2_FWD_EN
  logic                    fwd_valid;
  logic [4:0]              fwd_rd;
  logic [31:0]             fwd_data;
  logic                    fwd_data_ok;

  modport master (
    output flush, next_rdy_in, pass_in,
    output dc_resp_valid, dc_resp_data,
    input  rdy_in, pass_out,
    input  fwd_valid, fwd_rd, fwd_data, fwd_data_ok
  );

  modport slave (
    input  flush, next_rdy_in, pass_in,
    input  dc_resp_valid, dc_resp_data,
    output rdy_in, pass_out,
    output fwd_valid, fwd_rd, fwd_data, fwd_data_ok
  );
`else
  modport master (
    output flush, next_rdy_in, pass_in,
    output dc_resp_valid, dc_resp_data,
    input  rdy_in, pass_out
  );

  modport slave (
    input  flush, next_rdy_in, pass_in,
    input  dc_resp_valid, dc_resp_data,
    output rdy_in, pass_out
  );
`endif

endinterface

// File: rtl/memory2.sv
// Second memory stage: waits for dcache load data, extends it, hands off.
// Optional decode forwarding port enabled by MEM2_FWD_EN.
module memory2
  import memory2_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  memory2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HAVE,
    DRAIN
  } state_t;

  state_t                  state;
  memory1_memory2_pass_t   r;
  memory2_writeback_pass_t po;
  logic [31:0]             resp_buf;
  logic                    ld_held;
  logic                    m2_flush;
  logic                    m2_stall;
  logic                    load_wait;
  logic [31:0]             word;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    sx;
  logic [31:0]             ld_val;
  logic [31:0]             ex_mem_out;

  assign ld_held   = r.valid & r.is_ld;
  assign m2_flush  = bus.flush | ~r.valid;
  assign load_wait = ld_held & ~bus.flush
                   & (state != HAVE) & ~bus.dc_resp_valid;
  assign m2_stall  = ~bus.next_rdy_in | load_wait
                   | (state == DRAIN);
  assign bus.rdy_in = (m2_flush & (state != DRAIN))
                    | ~m2_stall;

  // Buffered data wins once the response has already gone by.
  assign word = (state == HAVE) ? resp_buf
                                : bus.dc_resp_data;
  assign sx   = ~r.mem_type[2];

  always_comb begin
    byte_v = word[7:0];
    unique case (r.pa[1:0])
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = r.pa[1] ? word[31:16] : word[15:0];
    ld_val = word;
    unique case (1'b1)
      (r.mem_type[1:0] == 2'd0):
        ld_val = {{24{sx & byte_v[7]}}, byte_v};
      (r.mem_type[1:0] == 2'd1):
        ld_val = {{16{sx & half_v[15]}}, half_v};
      default:
        ld_val = word;
    endcase
  end

  assign ex_mem_out = r.is_ld ? ld_val : r.ex_out;

  always_comb begin
    po                   = '0;
    po.valid             = ~m2_flush & ~m2_stall;
    po.pc                = r.pc;
    po.inst              = r.inst;
    po.rd                = r.rd;
    po.is_wr_rd          = r.is_wr_rd;
    po.is_wr_rd_pc_plus4 = r.is_wr_rd_pc_plus4;
    po.pc_plus4          = r.pc_plus4;
    po.is_wr_csr         = r.is_wr_csr;
    po.csr_addr          = r.csr_addr;
    po.is_ld             = r.is_ld;
    po.is_st             = r.is_st;
    po.mem_type          = r.mem_type;
    po.va                = r.va;
    po.pa                = r.pa;
    po.ex_mem_out        = ex_mem_out;
    po.st_data           = r.st_data;
  end

  assign bus.pass_out = po;

`ifdef MEM2_FWD_EN
  assign bus.fwd_valid   = ~m2_flush & r.is_wr_rd;
  assign bus.fwd_rd      = r.rd;
  assign bus.fwd_data    = r.is_wr_rd_pc_plus4 ? r.pc_plus4
                                               : ex_mem_out;
  assign bus.fwd_data_ok = ~load_wait;
`endif

  // A flushed load still owes one response; DRAIN swallows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      resp_buf <= '0;
    end else begin
      if (bus.rdy_in) r <= bus.pass_in;
      unique case (state)
        IDLE, WAIT: begin
          if (!ld_held) begin
            state <= IDLE;
          end else if (bus.flush) begin
            state <= bus.dc_resp_valid ? IDLE : DRAIN;
          end else if (bus.dc_resp_valid) begin
            if (!bus.next_rdy_in) begin
              state    <= HAVE;
              resp_buf <= bus.dc_resp_data;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= WAIT;
          end
        end
        HAVE: begin
          if (bus.flush | bus.next_rdy_in) state <= IDLE;
        end
        DRAIN: begin
          if (bus.dc_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory2.sv
// Bench for memory2: directed scenarios plus randomized traffic,
// outputs checked by a scoreboard monitor against a load-extension model.
module tb_memory2;
  import memory2_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic [31:0] ld_data = '0;
  logic [2:0]  mts[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  memory2_if bus ();

  memory2 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Load result from the size/sign rules, as shift-and-mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] d,
                                           input logic [2:0] mt,
                                           input logic [1:0] off);
    int unsigned size;
    int unsigned sh;
    logic [31:0] v;
    logic [31:0] mask;
    size = (mt[1:0] == 2'd0) ? 1 : (mt[1:0] == 2'd1) ? 2 : 4;
    if (size == 4) return d;
    sh   = (size == 2) ? (int'(off) / 2) * 16 : int'(off) * 8;
    mask = (32'd1 << (size * 8)) - 32'd1;
    v    = (d >> sh) & mask;
    if (!mt[2] && v[size*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic memory1_memory2_pass_t mk_ld(input logic [2:0] mt,
                                                  input logic [31:0] pa);
    memory1_memory2_pass_t p;
    p          = '0;
    p.valid    = 1'b1;
    p.is_ld    = 1'b1;
    p.mem_type = mt;
    p.pa       = pa;
    p.va       = pa;
    p.pc       = $urandom;
    p.pc_plus4 = p.pc + 32'd4;
    p.rd       = 5'd3;
    p.is_wr_rd = 1'b1;
    p.ex_out   = $urandom;
    return p;
  endfunction

  function automatic memory1_memory2_pass_t mk_alu(input logic [31:0] exo);
    memory1_memory2_pass_t p;
    p          = '0;
    p.valid    = 1'b1;
    p.pc       = $urandom;
    p.pc_plus4 = p.pc + 32'd4;
    p.rd       = 5'd7;
    p.is_wr_rd = 1'b1;
    p.ex_out   = exo;
    return p;
  endfunction

  function automatic memory1_memory2_pass_t rnd_inst();
    memory1_memory2_pass_t p;
    p          = '0;
    p.valid    = ($urandom_range(0, 3) != 0);
    p.pc       = $urandom;
    p.inst     = $urandom;
    p.rd       = 5'($urandom);
    p.is_wr_rd = 1'($urandom);
    p.pc_plus4 = p.pc + 32'd4;
    p.is_ld    = 1'($urandom);
    p.is_st    = ~p.is_ld & 1'($urandom);
    p.mem_type = mts[$urandom_range(0, 4)];
    p.pa       = $urandom;
    p.va       = p.pa;
    p.ex_out   = $urandom;
    p.st_data  = $urandom;
    return p;
  endfunction

  // One cycle of stimulus; the expected output is queued on acceptance.
  task automatic drive(input memory1_memory2_pass_t p, input logic nr,
                       input logic fl, input logic rv,
                       input logic [31:0] rdat, output bit acc);
    exp_t e;
    @(negedge clk);
    rst_n             = 1'b1;
    bus.pass_in       = p;
    bus.next_rdy_in   = nr;
    bus.flush         = fl;
    bus.dc_resp_valid = rv;
    bus.dc_resp_data  = rdat;
    #1;
    if (fl && q.size() > 0) void'(q.pop_back());
    acc = bus.rdy_in && p.valid;
    if (acc) begin
      e.pc  = p.pc;
      e.val = p.is_ld ? ref_load(ld_data, p.mem_type, p.pa[1:0])
                      : p.ex_out;
      q.push_back(e);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n             = 1'b0;
      bus.pass_in       = '0;
      bus.next_rdy_in   = 1'b1;
      bus.flush         = 1'b0;
      bus.dc_resp_valid = 1'b0;
      bus.dc_resp_data  = $urandom;
      q.delete();
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.pass_out.valid && bus.next_rdy_in) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_spurious act=valid exp=none pc=%h",
                 bus.pass_out.pc);
      end else begin
        e = q.pop_front();
        chk("sb_pc", bus.pass_out.pc, e.pc);
        chk("sb_data", bus.pass_out.ex_mem_out, e.val);
      end
    end
  end

  initial begin
    memory1_memory2_pass_t idle;
    memory1_memory2_pass_t p;
    bit acc;
    bit pend;
    int cnt;
    logic [31:0] pdata;
    logic nr;
    logic fl;
    logic rv;
    logic [31:0] rdat;

    idle = '0;
    pend = 1'b0;
    cnt = 0;
    pdata = '0;
    bus.pass_in = '0;
    bus.next_rdy_in = 1'b1;
    bus.flush = 1'b0;
    bus.dc_resp_valid = 1'b0;
    bus.dc_resp_data = '0;

    reset_cycles(3);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("rst_rdy", 32'(bus.rdy_in), 32'd1);
    chk("rst_valid", 32'(bus.pass_out.valid), 32'd0);

    // ld.b at lane 3, response in first held cycle
    ld_data = 32'h80FF_FFFF;
    drive(mk_ld(3'd0, 32'h0000_1003), 1, 0, 0, $urandom, acc);
    chk("lb_acc", 32'(acc), 32'd1);
    drive(idle, 1, 0, 1, 32'h80FF_FFFF, acc);
    chk("lb_valid", 32'(bus.pass_out.valid), 32'd1);
    chk("lb_data", bus.pass_out.ex_mem_out, 32'hFFFF_FF80);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("lb_once", 32'(bus.pass_out.valid), 32'd0);

    // ld.hu at lane 2, response three cycles late
    ld_data = 32'h8001_1234;
    drive(mk_ld(3'd5, 32'h0000_2002), 1, 0, 0, $urandom, acc);
    for (int i = 0; i < 3; i++) begin
      drive(idle, 1, 0, 0, $urandom, acc);
      chk("lhu_rdy", 32'(bus.rdy_in), 32'd0);
      chk("lhu_hold", 32'(bus.pass_out.valid), 32'd0);
    end
    drive(idle, 1, 0, 1, 32'h8001_1234, acc);
    chk("lhu_valid", 32'(bus.pass_out.valid), 32'd1);
    chk("lhu_data", bus.pass_out.ex_mem_out, 32'h0000_8001);

    // ld.w response during backpressure, buffered
    ld_data = 32'hDEAD_BEEF;
    drive(mk_ld(3'd2, 32'h0000_3001), 1, 0, 0, $urandom, acc);
    drive(idle, 0, 0, 1, 32'hDEAD_BEEF, acc);
    chk("lw_bp_rdy", 32'(bus.rdy_in), 32'd0);
    drive(idle, 0, 0, 0, 32'h1111_2222, acc);
    chk("lw_bp_valid", 32'(bus.pass_out.valid), 32'd0);
    drive(idle, 1, 0, 0, 32'h3333_4444, acc);
    chk("lw_buf_valid", 32'(bus.pass_out.valid), 32'd1);
    chk("lw_buf_data", bus.pass_out.ex_mem_out, 32'hDEAD_BEEF);

    // flush while waiting, response arrives two cycles later
    ld_data = $urandom;
    drive(mk_ld(3'd2, 32'h0000_4000), 1, 0, 0, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    drive(idle, 1, 1, 0, $urandom, acc);
    chk("fl_valid", 32'(bus.pass_out.valid), 32'd0);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("drain_rdy0", 32'(bus.rdy_in), 32'd0);
    chk("drain_valid0", 32'(bus.pass_out.valid), 32'd0);
    drive(idle, 1, 0, 1, $urandom, acc);
    chk("drain_rdy1", 32'(bus.rdy_in), 32'd0);
    chk("drain_valid1", 32'(bus.pass_out.valid), 32'd0);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("drain_done", 32'(bus.rdy_in), 32'd1);

    // flush coincident with the response: nothing to drain
    drive(mk_ld(3'd2, 32'h0000_5000), 1, 0, 0, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    drive(idle, 1, 1, 1, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("flresp_rdy", 32'(bus.rdy_in), 32'd1);

    // non-memory op passes straight through
    drive(mk_alu(32'h0000_1234), 1, 0, 0, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("alu_valid", 32'(bus.pass_out.valid), 32'd1);
    chk("alu_data", bus.pass_out.ex_mem_out, 32'h0000_1234);
`ifdef MEM2_FWD_EN
    chk("fwd_valid", 32'(bus.fwd_valid), 32'd1);
    chk("fwd_ok", 32'(bus.fwd_data_ok), 32'd1);
    chk("fwd_data", bus.fwd_data, 32'h0000_1234);
`endif

    // reset while waiting for a response
    drive(mk_ld(3'd2, 32'h0000_6000), 1, 0, 0, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    reset_cycles(1);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("rstw_rdy", 32'(bus.rdy_in), 32'd1);
    chk("rstw_valid", 32'(bus.pass_out.valid), 32'd0);
    drive(mk_alu(32'hCAFE_0001), 1, 0, 0, $urandom, acc);
    chk("rstw_acc", 32'(acc), 32'd1);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("rstw_pass", 32'(bus.pass_out.valid), 32'd1);

    // randomized traffic with a one-outstanding-load dcache model
    for (int i = 0; i < 4000; i++) begin
      nr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      rv = 1'b0;
      rdat = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          rv = 1'b1;
          rdat = pdata;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      p = rnd_inst();
      if (fl) p.valid = 1'b0;
      ld_data = $urandom;
      drive(p, nr, fl, rv, rdat, acc);
      if (acc && p.is_ld) begin
        pend = 1'b1;
        cnt = $urandom_range(0, 3);
        pdata = ld_data;
      end
    end

    for (int k = 0; k < 20 && (q.size() > 0 || pend); k++) begin
      rv = 1'b0;
      rdat = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          rv = 1'b1;
          rdat = pdata;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      drive(idle, 1, 0, rv, rdat, acc);
    end
    drive(idle, 1, 0, 0, $urandom, acc);
    drive(idle, 1, 0, 0, $urandom, acc);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
